// File: rtl/knn_train_loader.sv
// knn_train_loader: buffers labelled training samples in a small FIFO and
// writes them in order into the k-NN classifier's training memory, stalling
// whenever the classifier is reading that memory.
module knn_train_loader #(
    parameter int DEPTH      = 16,
    parameter int FEAT_W     = 7,
    parameter int LBL_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [FEAT_W-1:0]        s_feature,
    input  logic [LBL_W-1:0]         s_label,
    input  logic                     s_last,
    input  logic                     mem_busy,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [LBL_W+FEAT_W-1:0]  mem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     loaded,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = LBL_W + FEAT_W;
    localparam int EW = DW + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_CNT     = CW'(DEPTH);
    localparam logic [LW-1:0] FIFO_FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR      = PW'(FIFO_DEPTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [LW-1:0] fifoLevel_q, fifoLevel_d;
    logic [EW-1:0] fifoMem_q [FIFO_DEPTH];

    logic          memWe_q;
    logic [AW-1:0] memAddr_q;
    logic [DW-1:0] memWdata_q;
    logic [CW-1:0] count_q;
    logic          loaded_q;
    logic          overflow_q;

    logic          fifoFull;
    logic          fifoEmpty;
    logic          push;
    logic          pop;
    logic [EW-1:0] headEntry;
    logic          headLast;
    logic [CW-1:0] countInc;
    logic          finish;
    logic          discard;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign fifoFull  = (fifoLevel_q == FIFO_FULL_LVL);
    assign fifoEmpty = (fifoLevel_q == '0);

    // Ready is held low while reset is asserted so nothing is offered a handshake mid-reset.
    assign s_ready = !rst && (state_q != DONE) && !fifoFull;

    assign push      = s_valid && s_ready && !clear;
    assign pop       = !fifoEmpty && !mem_busy && (state_q != DONE) && !clear;
    assign headEntry = fifoMem_q[rdPtr_q];
    assign headLast  = headEntry[EW-1];
    assign countInc  = count_q + CW'(1);

    // The load completes on the write of a last-tagged entry or of the entry that fills memory.
    assign finish  = pop && (headLast || (countInc == DEPTH_CNT));
    // Filling memory on a non-last entry while more samples are queued means those samples are lost.
    assign discard = finish && !headLast && ((fifoLevel_q > LW'(1)) || push);

    // Next-state for the FSM and the FIFO bookkeeping; completing the load flushes the FIFO.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        fifoLevel_d = fifoLevel_q;
        if (finish) begin
            state_d     = DONE;
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            fifoLevel_d = '0;
        end else begin
            if (state_q == IDLE && push) begin
                state_d = LOAD;
            end
            if (push) begin
                wrPtr_d = nextPtr(wrPtr_q);
            end
            if (pop) begin
                rdPtr_d = nextPtr(rdPtr_q);
            end
            if (push && !pop) begin
                fifoLevel_d = fifoLevel_q + LW'(1);
            end else if (pop && !push) begin
                fifoLevel_d = fifoLevel_q - LW'(1);
            end
        end
    end

    // FIFO storage needs no reset; the level and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {s_last, s_label, s_feature};
        end
    end

    // Control registers and the registered memory write port; clear overrides everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoLevel_q <= '0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            count_q     <= '0;
            loaded_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoLevel_q <= '0;
            memWe_q     <= 1'b0;
            count_q     <= '0;
            loaded_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fifoLevel_q <= fifoLevel_d;
            memWe_q     <= pop;
            if (pop) begin
                memAddr_q  <= count_q[AW-1:0];
                memWdata_q <= headEntry[DW-1:0];
                count_q    <= countInc;
            end
            loaded_q   <= (state_q == DONE);
            overflow_q <= overflow_q | discard;
        end
    end

    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign count     = count_q;
    assign loaded    = loaded_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_knn_train_loader.sv
// tb_knn_train_loader: directed-vector bench for the k-NN training-set loader.
module tb_knn_train_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [6:0] s_feature = '0;
    logic [1:0] s_label = '0;
    logic       s_last = 1'b0;
    logic       mem_busy = 1'b0;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [8:0] mem_wdata;
    logic [4:0] count;
    logic       loaded;
    logic       overflow;

    int         vectorCount = 0;
    int         missCount = 0;
    int         cyc = 0;
    logic       busyAtEdge = 1'b0;
    int         busyWrites = 0;
    int         logCount = 0;
    logic [3:0] logAddr [64];
    logic [8:0] logData [64];
    int         logCyc [64];
    int         loadedRiseCyc = -1;
    logic       loadedPrev = 1'b0;
    int         lastAcceptCyc = 0;
    int         firstAcceptCyc = 0;
    int         sentCount = 0;

    knn_train_loader #(
        .DEPTH(16), .FEAT_W(7), .LBL_W(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_feature(s_feature), .s_label(s_label), .s_last(s_last),
        .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .loaded(loaded), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Logs every memory write with its cycle, and flags writes decided while busy was high.
    always @(posedge clk) begin
        busyAtEdge = mem_busy;
        cyc = cyc + 1;
        #1;
        if (mem_we === 1'b1) begin
            if (busyAtEdge) busyWrites++;
            if (logCount < 64) begin
                logAddr[logCount] = mem_addr;
                logData[logCount] = mem_wdata;
                logCyc[logCount]  = cyc;
            end
            logCount++;
        end
        if (loaded === 1'b1 && !loadedPrev) loadedRiseCyc = cyc;
        loadedPrev = (loaded === 1'b1);
    end

    // Hard time limit so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [8:0] packEntry(input logic [6:0] f, input logic [1:0] l);
        return {l, f};
    endfunction

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; clear = 1'b0; mem_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        logCount = 0; busyWrites = 0; loadedRiseCyc = -1;
    endtask

    // Offers one sample, retrying on each cycle until accepted or maxWait cycles pass.
    task automatic applyStimulus(input logic [6:0] f, input logic [1:0] l, input logic last,
                                 input int maxWait, output bit ok);
        ok = 1'b0;
        for (int w = 0; w < maxWait; w++) begin
            @(negedge clk);
            s_valid = 1'b1; s_feature = f; s_label = l; s_last = last;
            #1;
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                lastAcceptCyc = cyc + 1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0; s_last = 1'b0;
        end
    endtask

    initial begin
        bit         ok;
        bit         okBp;
        int         accCount;
        int         preCount;
        logic [8:0] basicExp [3];
        basicExp = '{9'h177, 9'h005, 9'h0C0};

        // Reset state while rst is held
        #12;
        checkOutput("rst_ready",  32'(s_ready), 0);
        checkOutput("rst_we",     32'(mem_we), 0);
        checkOutput("rst_addr",   32'(mem_addr), 0);
        checkOutput("rst_wdata",  32'(mem_wdata), 0);
        checkOutput("rst_count",  32'(count), 0);
        checkOutput("rst_loaded", 32'(loaded), 0);
        checkOutput("rst_ovf",    32'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rel_ready", 32'(s_ready), 1);

        // Basic load of three samples, back to back
        applyStimulus(7'd119, 2'd2, 1'b0, 4, ok);
        firstAcceptCyc = lastAcceptCyc;
        checkOutput("basic_acc0", 32'(ok), 1);
        applyStimulus(7'd5, 2'd0, 1'b0, 4, ok);
        checkOutput("basic_acc1", 32'(ok), 1);
        applyStimulus(7'd64, 2'd1, 1'b1, 4, ok);
        checkOutput("basic_acc2", 32'(ok), 1);
        idle(5);
        checkOutput("basic_nwr", logCount, 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("basic_addr%0d", i), 32'(logAddr[i]), i);
            checkOutput($sformatf("basic_data%0d", i), 32'(logData[i]), 32'(basicExp[i]));
        end
        checkOutput("basic_latency", logCyc[0], firstAcceptCyc + 1);
        checkOutput("basic_thru", logCyc[2], logCyc[0] + 2);
        checkOutput("basic_loaded_rise", loadedRiseCyc, logCyc[2] + 1);
        checkOutput("basic_count", 32'(count), 3);
        checkOutput("basic_loaded", 32'(loaded), 1);
        checkOutput("basic_ready", 32'(s_ready), 0);
        checkOutput("basic_ovf", 32'(overflow), 0);

        // Backpressure: busy for 10 cycles while 8 samples are offered
        resetDut();
        @(negedge clk);
        mem_busy = 1'b1;
        sentCount = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus(7'(i * 9 + 3), 2'(i % 4), 1'b0, 40, okBp);
                    if (okBp) sentCount++;
                end
            end
            begin
                repeat (10) @(negedge clk);
                #2;
                checkOutput("bp_accepted", sentCount, 4);
                checkOutput("bp_ready", 32'(s_ready), 0);
                checkOutput("bp_nowrite", logCount, 0);
                mem_busy = 1'b0;
            end
        join
        idle(12);
        checkOutput("bp_sent", sentCount, 8);
        checkOutput("bp_nwr", logCount, 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("bp_addr%0d", i), 32'(logAddr[i]), i);
            checkOutput($sformatf("bp_data%0d", i), 32'(logData[i]),
                        32'(packEntry(7'(i * 9 + 3), 2'(i % 4))));
        end
        checkOutput("bp_busywr", busyWrites, 0);
        checkOutput("bp_count", 32'(count), 8);
        checkOutput("bp_loaded", 32'(loaded), 0);

        // Overflow: 18 samples without last into a 16-entry memory
        resetDut();
        accCount = 0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(7'(i + 20), 2'(i % 4), 1'b0, (i < 17) ? 10 : 5, ok);
            if (ok) accCount++;
            if (i == 16) checkOutput("ovf_acc17", 32'(ok), 1);
            if (i == 17) checkOutput("ovf_rej18", 32'(ok), 0);
        end
        idle(4);
        checkOutput("ovf_accepted", accCount, 17);
        checkOutput("ovf_nwr", logCount, 16);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("ovf_data%0d", i), 32'(logData[i]),
                        32'(packEntry(7'(i + 20), 2'(i % 4))));
        end
        checkOutput("ovf_addr15", 32'(logAddr[15]), 15);
        checkOutput("ovf_loaded", 32'(loaded), 1);
        checkOutput("ovf_flag", 32'(overflow), 1);
        checkOutput("ovf_count", 32'(count), 16);
        checkOutput("ovf_ready", 32'(s_ready), 0);

        // Exact fill: last on the 16th sample
        resetDut();
        accCount = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(7'(100 - i), 2'(3 - (i % 4)), (i == 15), 10, ok);
            if (ok) accCount++;
        end
        idle(4);
        checkOutput("fill_accepted", accCount, 16);
        checkOutput("fill_nwr", logCount, 16);
        checkOutput("fill_addr15", 32'(logAddr[15]), 15);
        checkOutput("fill_data15", 32'(logData[15]), 32'(packEntry(7'd85, 2'd0)));
        checkOutput("fill_loaded", 32'(loaded), 1);
        checkOutput("fill_ovf", 32'(overflow), 0);
        checkOutput("fill_count", 32'(count), 16);

        // Clear after 5 writes with 2 samples held in the FIFO
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(7'(i + 1), 2'(i % 4), 1'b0, 10, ok);
        end
        idle(3);
        checkOutput("clr_pre_nwr", logCount, 5);
        @(negedge clk);
        mem_busy = 1'b1;
        applyStimulus(7'd50, 2'd1, 1'b0, 10, ok);
        checkOutput("clr_buf0", 32'(ok), 1);
        applyStimulus(7'd51, 2'd2, 1'b0, 10, ok);
        checkOutput("clr_buf1", 32'(ok), 1);
        @(negedge clk);
        s_valid = 1'b0;
        checkOutput("clr_pre_count", 32'(count), 5);
        clear = 1'b1;
        mem_busy = 1'b0;
        @(negedge clk);
        checkOutput("clr_we", 32'(mem_we), 0);
        checkOutput("clr_count", 32'(count), 0);
        checkOutput("clr_loaded", 32'(loaded), 0);
        checkOutput("clr_nwr", logCount, 5);
        preCount = logCount;
        clear = 1'b0;
        applyStimulus(7'd77, 2'd3, 1'b1, 10, ok);
        idle(4);
        checkOutput("clr_post_nwr", logCount, preCount + 1);
        checkOutput("clr_post_addr", 32'(logAddr[preCount]), 0);
        checkOutput("clr_post_data", 32'(logData[preCount]), 32'(packEntry(7'd77, 2'd3)));
        checkOutput("clr_post_count", 32'(count), 1);
        checkOutput("clr_post_loaded", 32'(loaded), 1);

        // Asynchronous reset in the middle of a stream
        resetDut();
        applyStimulus(7'd10, 2'd0, 1'b0, 10, ok);
        applyStimulus(7'd11, 2'd1, 1'b0, 10, ok);
        applyStimulus(7'd12, 2'd2, 1'b0, 10, ok);
        checkOutput("ar_pre_we", 32'(mem_we), 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("ar_we", 32'(mem_we), 0);
        checkOutput("ar_count", 32'(count), 0);
        checkOutput("ar_loaded", 32'(loaded), 0);
        checkOutput("ar_ready", 32'(s_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0;
        logCount = 0;
        applyStimulus(7'd42, 2'd1, 1'b1, 10, ok);
        idle(4);
        checkOutput("ar_post_nwr", logCount, 1);
        checkOutput("ar_post_addr", 32'(logAddr[0]), 0);
        checkOutput("ar_post_data", 32'(logData[0]), 32'(packEntry(7'd42, 2'd1)));
        checkOutput("ar_post_count", 32'(count), 1);
        checkOutput("ar_post_loaded", 32'(loaded), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/knn_train_loader.md
# knn_train_loader

Training-set writer for the k-NN classifier. Accepts labelled training samples over a valid/ready stream, buffers them in a small FIFO, and writes them sequentially into the classifier's training memory. It stalls while the classifier is reading that memory. It raises `loaded` once the set is complete, after which the classifier may be fed `unknown` queries.

## Interface
Parameters:
- `DEPTH`, 16: training-memory entries.
- `FEAT_W`, 7: feature width; matches the classifier's `unknown` input.
- `LBL_W`, 2: class label width.
- `FIFO_DEPTH`, 4: input buffer entries.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous restart of the load.
- `s_valid`  in  1  sample present.
- `s_ready`  out  1  loader can accept a sample.
- `s_feature`  in  FEAT_W  sample feature.
- `s_label`  in  LBL_W  sample class.
- `s_last`  in  1  marks the final training sample.
- `mem_busy`  in  1  classifier is reading training memory; no writes allowed.
- `mem_we`  out  1  write strobe, registered.
- `mem_addr`  out  clog2(DEPTH)  write address, registered.
- `mem_wdata`  out  LBL_W+FEAT_W  `{label, feature}`, registered.
- `count`  out  clog2(DEPTH)+1  entries written so far.
- `loaded`  out  1  training set complete.
- `overflow`  out  1  sticky; samples were discarded because memory was full.

## Operation
- FSM states are IDLE, LOAD and DONE.
  - IDLE → LOAD on the first accepted sample.
  - LOAD → DONE on the edge that writes an entry whose `last` is set, or the entry that makes `count` reach DEPTH.
- Accept rule: a sample is accepted on an edge where `s_valid && s_ready`. It is pushed into the FIFO with its `last` bit.
- `s_ready` = `(state != DONE) && !fifo_full`. This is combinational from registered state. There is no push while full, even if a pop occurs in the same cycle.
- Pop rule: pop when `fifo_nonempty && !mem_busy && state != DONE && !clear`. A pop registers:
  - `mem_we` = 1,
  - `mem_addr` = `count`,
  - `mem_wdata` = `{label, feature}`,
  - `count` incremented.
- When no pop occurs, `mem_we` = 0. `mem_addr` and `mem_wdata` hold their last values.
- Entering DONE flushes any remaining FIFO entries.
  - If DONE was reached through `count == DEPTH` on a non-last entry, and the FIFO still holds at least one entry, `overflow` is set.
  - `s_last` arriving exactly on entry DEPTH gives no overflow.
- `loaded` is registered. It rises on the edge after the final `mem_we` cycle and stays high in DONE.
- DONE is held until `clear` or `rst`.
- `clear` has priority over pushes and pops in its cycle. It resets to IDLE and clears the FIFO, `count`, `loaded`, `overflow` and `mem_we`.
- `mem_busy` may toggle at any time and only stalls pops. Entry order is strictly preserved.

## Timing
- Reset values (asynchronous, immediate on `rst` rise):
  - state IDLE, FIFO empty;
  - `mem_we` 0, `mem_addr` 0, `mem_wdata` 0;
  - `count` 0, `loaded` 0, `overflow` 0;
  - `s_ready` 0 while `rst` is high, 1 from the first cycle after release.
- Latency: a sample accepted at edge k, with an empty FIFO and `mem_busy` low, gives `mem_we` high in the cycle after edge k+1.
- Throughput: one sample per cycle while `mem_busy` is low.
- With `mem_busy` held high, exactly FIFO_DEPTH samples are accepted before `s_ready` falls.
- A pop is decided from `mem_busy` as sampled in that same cycle. No write is issued in any cycle where `mem_busy` was high at the preceding edge's decision.
- `rst` asserted mid-write drops `mem_we` asynchronously. A partially loaded set is discarded.

## Test plan
- Basic load: stream (119,2),(5,0),(64,1 with last) back-to-back.
  - Writes go to addr 0,1,2 with `mem_wdata` 9'h177, 9'h005, 9'h0C0.
  - `count`=3; `loaded`=1 one cycle after the third write; `s_ready`=0 thereafter.
- Backpressure: raise `mem_busy` for 10 cycles while offering 8 samples.
  - 4 accepted, then `s_ready`=0; no `mem_we` while busy.
  - All 8 written in order at addr 0–7 after release.
- Overflow: offer 18 samples without `s_last`, DEPTH=16.
  - 16 writes; `loaded`=1; `overflow`=1; samples 17–18 never written.
- Exact fill: 16 samples with `s_last` on the 16th.
  - `loaded`=1, `overflow`=0.
- Clear: pulse `clear` after 5 writes while the FIFO holds 2 entries.
  - Same cycle: no write; `count`=0, `loaded`=0.
  - The next sample is written to addr 0.
- Async reset: assert `rst` mid-stream between edges.
  - `mem_we`, `count`, `loaded` and `s_ready` go to 0 before the next edge.
  - Loading restarts cleanly at addr 0 after release.
